// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size
// encodings and the alignment rule used by the datapath.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // waiting for a request
    S_RD   = 3'd1,  // memory address driven, read in flight
    S_CAP  = 3'd2,  // read word valid: extract load value or merge store
    S_WR   = 3'd3,  // write enable high for one cycle
    S_FIN  = 3'd4   // completion pulse
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Halfwords need an even address, words a 4-byte aligned one; the
  // reserved size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = offset[0];
      SIZE_W:  is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for a big-endian word: extracts and extends
// byte/half loads, merges byte/half stores into the old word, and flags
// misaligned accesses. Byte offset 0 is bits [31:24].
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_ld,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_value,
  output logic [31:0] o_merged_word,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lanes and extend or merge them.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    w_byte        = i_word[31:24];
    w_half        = i_word[31:16];
    o_load_value  = i_word;
    o_merged_word = i_word;

    case (i_offset)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

    case (i_size)
      SIZE_B: begin
        o_load_value = {{24{~i_unsigned_ld & w_byte[7]}}, w_byte};
        case (i_offset)
          2'd0:    o_merged_word[31:24] = i_store_data[7:0];
          2'd1:    o_merged_word[23:16] = i_store_data[7:0];
          2'd2:    o_merged_word[15:8]  = i_store_data[7:0];
          default: o_merged_word[7:0]   = i_store_data[7:0];
        endcase
      end
      SIZE_H: begin
        o_load_value = {{16{~i_unsigned_ld & w_half[15]}}, w_half};
        if (i_offset[1]) o_merged_word[15:0]  = i_store_data[15:0];
        else             o_merged_word[31:16] = i_store_data[15:0];
      end
      default: begin
        o_load_value  = i_word;
        o_merged_word = i_store_data;
      end
    endcase
  end

  assign o_misaligned = is_misaligned(i_size, i_offset);

endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the MEM stage and a word-wide data memory. Handles
// byte/half/word loads with sign or zero extension, word stores directly,
// and byte/half stores by read-modify-write. Misaligned requests complete
// immediately with a fault flag and never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_is_store,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned_ld,
  input  logic [31:0]       i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_misaligned,
  output logic [31:0]       o_mem_adress,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_is_store;
  logic [1:0]        r_size;
  logic              r_unsigned_ld;
  logic [1:0]        r_offset;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_load_data;
  logic              r_misaligned;
  logic [31:0]       r_mem_adress;
  logic [DATA_W-1:0] r_mem_write_data;

  logic              w_accept;
  logic              w_word_store;
  logic [1:0]        w_sel_size;
  logic [1:0]        w_sel_offset;
  logic [DATA_W-1:0] w_load_value;
  logic [DATA_W-1:0] w_merged_word;
  logic              w_misaligned;
  logic              w_unused_addr;

  assign w_accept     = (r_state == S_IDLE) && i_req;
  assign w_word_store = i_is_store && (i_size == SIZE_W);

  // The alignment check must see the live request while idle; afterwards
  // the lanes come from the captured request.
  assign w_sel_size   = (r_state == S_IDLE) ? i_size      : r_size;
  assign w_sel_offset = (r_state == S_IDLE) ? i_addr[1:0] : r_offset;

  // Byte-address bits above the memory window wrap and are deliberately ignored.
  assign w_unused_addr = &{1'b0, i_addr[31:MEM_AW+2]};

  lsu_align u_align (
    .i_word        (i_mem_read_data),
    .i_offset      (w_sel_offset),
    .i_size        (w_sel_size),
    .i_unsigned_ld (r_unsigned_ld),
    .i_store_data  (r_store_data),
    .o_load_value  (w_load_value),
    .o_merged_word (w_merged_word),
    .o_misaligned  (w_misaligned)
  );

  // State register with synchronous reset; a reset drops any pending access.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state sequencing for fault, load, word store and read-modify-write.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)      w_next_state = S_FIN;
          else if (w_word_store) w_next_state = S_WR;
          else                   w_next_state = S_RD;
        end
      end
      S_RD:    w_next_state = S_CAP;
      S_CAP:   w_next_state = r_is_store ? S_WR : S_FIN;
      S_WR:    w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture, load result and memory-port registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_is_store       <= 1'b0;
      r_size           <= SIZE_B;
      r_unsigned_ld    <= 1'b0;
      r_offset         <= 2'b00;
      r_store_data     <= '0;
      r_load_data      <= '0;
      r_misaligned     <= 1'b0;
      r_mem_adress     <= '0;
      r_mem_write_data <= '0;
    end else begin
      if (w_accept) begin
        r_is_store    <= i_is_store;
        r_size        <= i_size;
        r_unsigned_ld <= i_unsigned_ld;
        r_offset      <= i_addr[1:0];
        r_store_data  <= i_store_data;
        r_misaligned  <= w_misaligned;
        if (!w_misaligned) begin
          r_mem_adress <= {{(32-MEM_AW){1'b0}}, i_addr[MEM_AW+1:2]};
          if (w_word_store) r_mem_write_data <= i_store_data;
        end
      end
      if (r_state == S_CAP) begin
        if (r_is_store) r_mem_write_data <= w_merged_word;
        else            r_load_data      <= w_load_value;
      end
    end
  end

  assign o_ready          = (r_state == S_IDLE);
  assign o_done           = (r_state == S_FIN);
  assign o_load_data      = r_load_data;
  assign o_misaligned     = r_misaligned;
  assign o_mem_adress     = r_mem_adress;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_write      = (r_state == S_WR) && !i_reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors from a table,
// hand-written reset and held-request sequences, then random accesses
// checked against a byte-level reference model of memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        is_store;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        ready;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] mem_adress;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(8), .DATA_W(32)) dut (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_req            (req),
    .i_is_store       (is_store),
    .i_size           (size),
    .i_unsigned_ld    (unsigned_ld),
    .i_addr           (addr),
    .i_store_data     (store_data),
    .o_ready          (ready),
    .o_done           (done),
    .o_load_data      (load_data),
    .o_misaligned     (misaligned),
    .o_mem_adress     (mem_adress),
    .o_mem_write_data (mem_write_data),
    .o_mem_write      (mem_write),
    .i_mem_read_data  (mem_read_data)
  );

  // Memory model: registered 1-cycle read, posedge write, plus a bench preload port.
  logic [31:0] mem [256];
  logic        bk_we = 1'b0;
  logic [7:0]  bk_idx = '0;
  logic [31:0] bk_val = '0;
  int          wr_count = 0;
  int          done_count = 0;

  always @(posedge clk) begin
    if (bk_we) mem[bk_idx] <= bk_val;
    else if (mem_write) begin
      mem[mem_adress[7:0]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
    mem_read_data <= mem[mem_adress[7:0]];
    if (done) done_count <= done_count + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bk_we = 1'b1; bk_idx = 8'(idx); bk_val = val;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  // Wait (bounded) for ready, present one request, and report what happened.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] dt,
                           output int lat, output logic [31:0] ld,
                           output logic mis, output int wr_delta,
                           output logic [31:0] adr);
    int w0;
    int guard;
    w0 = wr_count;
    guard = 0;
    lat = -1; ld = 'x; mis = 1'bx; adr = 'x;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    is_store = st; size = sz; unsigned_ld = un; addr = ad; store_data = dt; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (done) begin
        lat = n; ld = load_data; mis = misaligned; adr = mem_adress;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_fin", 32'(ready), 32'd1);
    wr_delta = wr_count - w0;
  endtask

  // Reference model: memory as bytes, big-endian, computed from the access rules.
  logic [31:0] ref_mem [16];

  function automatic void ref_access(input logic st, input logic [1:0] sz, input logic un,
                                     input logic [31:0] ad, input logic [31:0] dt,
                                     input logic [31:0] prev_ld,
                                     output int lat, output logic [31:0] ld,
                                     output logic mis, output int wr);
    int idx;
    int off;
    int b [4];
    int v;
    logic [31:0] w;
    idx = int'(ad[5:2]);
    off = int'(ad[1:0]);
    mis = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    ld = prev_ld; wr = 0;
    if (mis) begin lat = 1; return; end
    w = ref_mem[idx];
    for (int k = 0; k < 4; k++) b[k] = int'((w >> (24 - 8 * k)) & 32'hFF);
    if (!st) begin
      lat = 3;
      if (sz == 2'd0) begin
        v = b[off];
        if (!un && v >= 128) v = v - 256;
        ld = 32'(v);
      end else if (sz == 2'd1) begin
        v = b[off] * 256 + b[off + 1];
        if (!un && v >= 32768) v = v - 65536;
        ld = 32'(v);
      end else ld = w;
    end else begin
      wr = 1;
      lat = (sz == 2'd2) ? 2 : 4;
      if (sz == 2'd0) b[off] = int'(dt & 32'hFF);
      else if (sz == 2'd1) begin
        b[off] = int'((dt >> 8) & 32'hFF);
        b[off + 1] = int'(dt & 32'hFF);
      end else for (int k = 0; k < 4; k++) b[k] = int'((dt >> (24 - 8 * k)) & 32'hFF);
      w = 0;
      for (int k = 0; k < 4; k++) w = w | (32'(b[k]) << (24 - 8 * k));
      ref_mem[idx] = w;
    end
  endfunction

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] dt;
    int          lat;
    logic [31:0] ld;
    logic        mis;
    int          wr;
    int          widx;
    logic [31:0] wval;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat;
    int          wrd;
    int          w0;
    int          d0;
    int          guard;
    logic [31:0] ld;
    logic [31:0] adr;
    logic        mis;
    int          e_lat;
    int          e_wr;
    logic [31:0] e_ld;
    logic        e_mis;
    logic [31:0] last_ld;
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] dt;

    reset = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = '0; store_data = '0;

    for (int i = 0; i < 16; i++) poke(i, 32'hC0DE_0000 | 32'(i));
    poke(4, 32'h8899_AABB);
    poke(2, 32'h1122_3344);

    // Reset state, sampled while reset is still asserted.
    @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
    check("rst_mem_adress", mem_adress, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //          st    sz     un    addr          data          lat ld             mis  wr widx wval
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h11,       32'h0,        3, 32'hFFFFFF99, 1'b0, 0, -1, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h11,       32'h0,        3, 32'h00000099, 1'b0, 0, -1, 32'h0};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h12,       32'h0,        3, 32'hFFFFAABB, 1'b0, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h10,       32'h0,        3, 32'h00008899, 1'b0, 0, -1, 32'h0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0B,       32'hFFFFFFA5, 4, 32'h00008899, 1'b0, 1,  2, 32'h112233A5};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h08,       32'h1234BEEF, 4, 32'h00008899, 1'b0, 1,  2, 32'hBEEF33A5};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h0C,       32'hDEADBEEF, 2, 32'h00008899, 1'b0, 1,  3, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h40C,      32'h0,        3, 32'hDEADBEEF, 1'b0, 0, -1, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h03,       32'h0,        1, 32'hDEADBEEF, 1'b1, 0,  0, 32'hC0DE0000};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h06,       32'h55555555, 1, 32'hDEADBEEF, 1'b1, 0,  1, 32'hC0DE0001};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h00,       32'h66666666, 1, 32'hDEADBEEF, 1'b1, 0,  0, 32'hC0DE0000};

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].st, vecs[i].sz, vecs[i].un, vecs[i].ad, vecs[i].dt, lat, ld, mis, wrd, adr);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_misaligned", i), 32'(mis), 32'(vecs[i].mis));
      check($sformatf("vec%0d_load_data", i), ld, vecs[i].ld);
      check($sformatf("vec%0d_writes", i), 32'(wrd), 32'(vecs[i].wr));
      if (vecs[i].widx >= 0)
        check($sformatf("vec%0d_mem", i), mem[vecs[i].widx], vecs[i].wval);
    end

    // Request held high across completions: one access per accept.
    w0 = wr_count; d0 = done_count;
    @(negedge clk);
    is_store = 1'b1; size = 2'd2; unsigned_ld = 1'b0; addr = 32'h14; store_data = 32'h1234_5678;
    req = 1'b1;
    repeat (6) @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_writes", 32'(wr_count - w0), 32'd2);
    check("held_dones", 32'(done_count - d0), 32'd2);
    check("held_mem", mem[5], 32'h1234_5678);
    check("held_ready", 32'(ready), 32'd1);

    // Byte store aborted by reset during the capture cycle.
    w0 = wr_count; d0 = done_count;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    is_store = 1'b1; size = 2'd0; addr = 32'h0B; store_data = 32'h5A; req = 1'b1;
    @(posedge clk); #1;   // read cycle
    @(posedge clk); #1;   // capture cycle
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_count - w0), 32'd0);
    check("abort_dones", 32'(done_count - d0), 32'd0);
    check("abort_mem", mem[2], 32'hBEEF33A5);
    check("abort_load_data", load_data, 32'd0);

    // Random accesses against the reference model; word index kept in 0..15
    // so stores and loads collide, upper address bits left random to exercise wrap.
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    last_ld = 32'd0;
    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      ad = $urandom & 32'hFFFF_FC3F;
      dt = $urandom;
      ref_access(st, sz, un, ad, dt, last_ld, e_lat, e_ld, e_mis, e_wr);
      do_access(st, sz, un, ad, dt, lat, ld, mis, wrd, adr);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
      check($sformatf("rnd%0d_misaligned", i), 32'(mis), 32'(e_mis));
      check($sformatf("rnd%0d_load_data", i), ld, e_ld);
      check($sformatf("rnd%0d_writes", i), 32'(wrd), 32'(e_wr));
      if (!e_mis) check($sformatf("rnd%0d_mem_adress", i), adr, 32'(ad[9:2]));
      if (st && !e_mis) check($sformatf("rnd%0d_mem", i), mem[ad[5:2]], ref_mem[ad[5:2]]);
      last_ld = e_ld;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
